// File: rtl/avalon_packet_enforcer_if.sv
// Avalon-ST interface: valid/rdy handshake with sop/eop framing, data and empty.
interface avalon_st_if #(
    parameter int unsigned DATA_WIDTH_IN_BYTES = 16
);
    localparam int unsigned DataW  = 8 * DATA_WIDTH_IN_BYTES;
    localparam int unsigned EmptyW = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

    logic              valid;
    logic              sop;
    logic              eop;
    logic [DataW-1:0]  data;
    logic [EmptyW-1:0] empty;
    logic              rdy;

    modport master (output valid, output sop, output eop, output data, output empty, input rdy);
    modport slave  (input valid, input sop, input eop, input data, input empty, output rdy);
endinterface

// File: rtl/avalon_packet_enforcer.sv
// Avalon-ST packet enforcer: repairs sop/eop framing from an untrusted source, truncates
// over-long packets and registers the repaired stream with full backpressure.
// Optional macro AVALON_ENFORCER_ERR_CNT_EN builds saturating per-error counters.
module avalon_packet_enforcer #(
    parameter int unsigned DATA_WIDTH_IN_BYTES = 16,
    parameter int unsigned MAX_PKT_WORDS       = 64,
    parameter int unsigned CNT_WIDTH           = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    avalon_st_if.slave           untrusted_msg,
    avalon_st_if.master          trusted_msg,
    output logic                 packet_didnt_started,
    output logic                 packet_in_packet,
    output logic                 packet_too_long,
    output logic [CNT_WIDTH-1:0] didnt_started_cnt,
    output logic [CNT_WIDTH-1:0] in_packet_cnt,
    output logic [CNT_WIDTH-1:0] too_long_cnt
);
    localparam int unsigned DataW  = 8 * DATA_WIDTH_IN_BYTES;
    localparam int unsigned EmptyW = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;
    localparam int unsigned BeatW  = $clog2(MAX_PKT_WORDS + 1);
    localparam logic [BeatW-1:0] MaxWords = BeatW'(MAX_PKT_WORDS);

    typedef enum logic [1:0] {StIdle, StInPkt, StDrop} state_e;

    state_e            state_q, state_d;
    logic [BeatW-1:0]  count_q, count_d;
    logic              valid_q, valid_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic [DataW-1:0]  data_q, data_d;
    logic [EmptyW-1:0] empty_q, empty_d;
    logic              didnt_q, didnt_d;
    logic              in_pkt_q, in_pkt_d;
    logic              too_long_q, too_long_d;

    logic              in_rdy;
    logic              accept;
    logic              emit;
    logic              emit_sop;
    logic              emit_eop;
    logic [EmptyW-1:0] emit_empty;

    // A new beat may enter whenever the output register is empty or being drained this cycle.
    assign in_rdy            = !valid_q || trusted_msg.rdy;
    assign untrusted_msg.rdy = in_rdy;
    assign accept            = untrusted_msg.valid && in_rdy;

    // Framing FSM: decide whether the accepted beat is emitted and how it is re-framed.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        emit       = 1'b0;
        emit_sop   = 1'b0;
        emit_eop   = 1'b0;
        emit_empty = '0;
        didnt_d    = 1'b0;
        in_pkt_d   = 1'b0;
        too_long_d = 1'b0;
        if (accept) begin
            unique case (state_q)
                StIdle, StDrop: begin
                    if (untrusted_msg.sop) begin
                        emit       = 1'b1;
                        emit_sop   = 1'b1;
                        emit_eop   = untrusted_msg.eop;
                        emit_empty = untrusted_msg.eop ? untrusted_msg.empty : '0;
                        if (untrusted_msg.eop) begin
                            state_d = StIdle;
                            count_d = '0;
                        end else begin
                            state_d = StInPkt;
                            count_d = BeatW'(1);
                        end
                    end else if (state_q == StIdle) begin
                        didnt_d = 1'b1;
                    end else if (untrusted_msg.eop) begin
                        // End of the truncated tail; framing is back in sync.
                        state_d = StIdle;
                    end
                end
                StInPkt: begin
                    emit = 1'b1;
                    if (untrusted_msg.sop) begin
                        // The colliding sop beat closes the open packet.
                        emit_eop = 1'b1;
                        in_pkt_d = 1'b1;
                        state_d  = StIdle;
                        count_d  = '0;
                    end else if (untrusted_msg.eop) begin
                        emit_eop   = 1'b1;
                        emit_empty = untrusted_msg.empty;
                        state_d    = StIdle;
                        count_d    = '0;
                    end else if (count_q + 1'b1 == MaxWords) begin
                        emit_eop   = 1'b1;
                        too_long_d = 1'b1;
                        state_d    = StDrop;
                        count_d    = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    count_d = '0;
                end
            endcase
        end
    end

    // Output register: load on emit, otherwise drop valid once downstream takes the beat.
    always_comb begin
        valid_d = valid_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        data_d  = data_q;
        empty_d = empty_q;
        if (emit) begin
            valid_d = 1'b1;
            sop_d   = emit_sop;
            eop_d   = emit_eop;
            data_d  = untrusted_msg.data;
            empty_d = emit_empty;
        end else if (trusted_msg.rdy) begin
            valid_d = 1'b0;
        end
    end

    // State, output stage and error pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            data_q     <= '0;
            empty_q    <= '0;
            didnt_q    <= 1'b0;
            in_pkt_q   <= 1'b0;
            too_long_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            data_q     <= data_d;
            empty_q    <= empty_d;
            didnt_q    <= didnt_d;
            in_pkt_q   <= in_pkt_d;
            too_long_q <= too_long_d;
        end
    end

    assign trusted_msg.valid    = valid_q;
    assign trusted_msg.sop      = sop_q;
    assign trusted_msg.eop      = eop_q;
    assign trusted_msg.data     = data_q;
    assign trusted_msg.empty    = empty_q;
    assign packet_didnt_started = didnt_q;
    assign packet_in_packet     = in_pkt_q;
    assign packet_too_long      = too_long_q;

`ifdef AVALON_ENFORCER_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] didnt_cnt_q, didnt_cnt_d;
    logic [CNT_WIDTH-1:0] in_pkt_cnt_q, in_pkt_cnt_d;
    logic [CNT_WIDTH-1:0] too_long_cnt_q, too_long_cnt_d;

    // Saturating counters step in the same edge that raises the matching pulse.
    always_comb begin
        didnt_cnt_d    = didnt_cnt_q;
        in_pkt_cnt_d   = in_pkt_cnt_q;
        too_long_cnt_d = too_long_cnt_q;
        if (didnt_d && (didnt_cnt_q != '1)) didnt_cnt_d = didnt_cnt_q + 1'b1;
        if (in_pkt_d && (in_pkt_cnt_q != '1)) in_pkt_cnt_d = in_pkt_cnt_q + 1'b1;
        if (too_long_d && (too_long_cnt_q != '1)) too_long_cnt_d = too_long_cnt_q + 1'b1;
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            didnt_cnt_q    <= '0;
            in_pkt_cnt_q   <= '0;
            too_long_cnt_q <= '0;
        end else begin
            didnt_cnt_q    <= didnt_cnt_d;
            in_pkt_cnt_q   <= in_pkt_cnt_d;
            too_long_cnt_q <= too_long_cnt_d;
        end
    end

    assign didnt_started_cnt = didnt_cnt_q;
    assign in_packet_cnt     = in_pkt_cnt_q;
    assign too_long_cnt      = too_long_cnt_q;
`else
    assign didnt_started_cnt = '0;
    assign in_packet_cnt     = '0;
    assign too_long_cnt      = '0;
`endif

endmodule

// File: tb/tb_avalon_packet_enforcer.sv
// Self-checking bench for avalon_packet_enforcer: directed scenarios plus random traffic,
// checked cycle by cycle against a packet-level reference model.
module tb_avalon_packet_enforcer;
    localparam int unsigned Bytes    = 4;
    localparam int unsigned MaxWords = 8;
    localparam int unsigned CntW     = 2;
    localparam int unsigned DW       = 8 * Bytes;
    localparam int unsigned EW       = 2;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
        logic [EW-1:0] empty;
    } beat_t;

    logic clk;
    logic rst;
    logic f_ds, f_ip, f_tl;
    logic [CntW-1:0] c_ds, c_ip, c_tl;

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(Bytes)) u_in ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(Bytes)) u_out ();

    avalon_packet_enforcer #(
        .DATA_WIDTH_IN_BYTES(Bytes),
        .MAX_PKT_WORDS      (MaxWords),
        .CNT_WIDTH          (CntW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .untrusted_msg       (u_in),
        .trusted_msg         (u_out),
        .packet_didnt_started(f_ds),
        .packet_in_packet    (f_ip),
        .packet_too_long     (f_tl),
        .didnt_started_cnt   (c_ds),
        .in_packet_cnt       (c_ip),
        .too_long_cnt        (c_tl)
    );

    int n_cmp = 0;
    int n_err = 0;
    int obs_ds = 0, obs_ip = 0, obs_tl = 0, obs_out = 0, obs_stall = 0;
    int rdy_mode = 0;
    int tog_ph = 0;

    // Reference model state: packet-level view of the input stream.
    beat_t    exp_q[$];
    bit       m_open, m_discard;
    int       m_len;
    bit       m_valid;
    bit [2:0] exp_flags;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    // Downstream ready pattern generator.
    initial begin
        u_out.rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: u_out.rdy = 1'b1;
                1: begin
                    u_out.rdy = (tog_ph == 0);
                    tog_ph = (tog_ph + 1) % 3;
                end
                default: u_out.rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    function automatic void model_step(input logic sop, input logic eop,
                                       input logic [DW-1:0] d, input logic [EW-1:0] e,
                                       output bit [2:0] fl, output bit pushed);
        beat_t b;
        fl = 3'b000;
        pushed = 1'b0;
        b.data = d;
        if (!m_open) begin
            if (sop) begin
                b.sop = 1'b1; b.eop = eop; b.empty = eop ? e : '0;
                exp_q.push_back(b);
                pushed = 1'b1;
                m_open = !eop;
                m_len = 1;
                m_discard = 1'b0;
            end else if (!m_discard) begin
                fl[2] = 1'b1;
            end else if (eop) begin
                m_discard = 1'b0;
            end
        end else begin
            pushed = 1'b1;
            b.sop = 1'b0;
            if (sop) begin
                b.eop = 1'b1; b.empty = '0;
                fl[1] = 1'b1;
                m_open = 1'b0;
            end else begin
                m_len++;
                if (eop) begin
                    b.eop = 1'b1; b.empty = e;
                    m_open = 1'b0;
                end else if (m_len == MaxWords) begin
                    b.eop = 1'b1; b.empty = '0;
                    fl[0] = 1'b1;
                    m_open = 1'b0;
                    m_discard = 1'b1;
                end else begin
                    b.eop = 1'b0; b.empty = '0;
                end
            end
            exp_q.push_back(b);
        end
    endfunction

    // Cycle monitor: compares the DUT against the model away from the active edge.
    always @(negedge clk) begin
        beat_t   got, want;
        bit      pushed;
        bit [2:0] fl;
        bit      nv;
        if (rst) begin
            exp_q.delete();
            m_open = 1'b0; m_discard = 1'b0; m_len = 0;
            m_valid = 1'b0; exp_flags = 3'b000;
        end else begin
            n_cmp++;
            if ({f_ds, f_ip, f_tl} !== exp_flags) begin
                n_err++;
                $display("FAIL flags at %0t: got %b required %b", $time, {f_ds, f_ip, f_tl},
                         exp_flags);
            end
            obs_ds += int'(f_ds === 1'b1);
            obs_ip += int'(f_ip === 1'b1);
            obs_tl += int'(f_tl === 1'b1);
            n_cmp++;
            if (u_out.valid !== m_valid) begin
                n_err++;
                $display("FAIL out_valid at %0t: got %b required %b", $time, u_out.valid, m_valid);
            end
            n_cmp++;
            if (u_in.rdy !== (!u_out.valid || u_out.rdy)) begin
                n_err++;
                $display("FAIL in_rdy at %0t: got %b required %b", $time, u_in.rdy,
                         !u_out.valid || u_out.rdy);
            end
            if (u_in.valid && !u_in.rdy) obs_stall++;
            nv = m_valid && !u_out.rdy;
            if (u_out.valid && u_out.rdy) begin
                obs_out++;
                n_cmp++;
                got = {u_out.sop, u_out.eop, u_out.data, u_out.empty};
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL out_beat at %0t: got %h required none", $time, got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_err++;
                        $display("FAIL out_beat at %0t: got sop%b eop%b d%h e%0d required sop%b eop%b d%h e%0d",
                                 $time, got.sop, got.eop, got.data, got.empty,
                                 want.sop, want.eop, want.data, want.empty);
                    end
                end
            end
            exp_flags = 3'b000;
            if (u_in.valid && u_in.rdy) begin
                model_step(u_in.sop, u_in.eop, u_in.data, u_in.empty, fl, pushed);
                exp_flags = fl;
                if (pushed) nv = 1'b1;
            end
            m_valid = nv;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic sop, input logic eop, input logic [DW-1:0] d,
                             input logic [EW-1:0] e);
        bit ok = 1'b0;
        u_in.valid = 1'b1; u_in.sop = sop; u_in.eop = eop; u_in.data = d; u_in.empty = e;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (u_in.rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: beat not accepted in 200 cycles, required accept");
        end
        @(posedge clk);
        #1;
        u_in.valid = 1'b0; u_in.sop = 1'b0; u_in.eop = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        rdy_mode = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && u_out.valid === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL drain: %0d beats still expected, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        u_in.valid = 1'b0; u_in.sop = 1'b0; u_in.eop = 1'b0; u_in.data = '0; u_in.empty = '0;
        idle(3);
        @(negedge clk);
        n_cmp++;
        if ({u_out.valid, u_out.sop, u_out.eop, u_out.data, u_out.empty} !== '0) begin
            n_err++;
            $display("FAIL reset_out: got v%b s%b e%b d%h m%0d required all 0", u_out.valid,
                     u_out.sop, u_out.eop, u_out.data, u_out.empty);
        end
        n_cmp++;
        if ({f_ds, f_ip, f_tl, c_ds, c_ip, c_tl} !== '0) begin
            n_err++;
            $display("FAIL reset_flags: got %b %0d %0d %0d required 0", {f_ds, f_ip, f_tl},
                     c_ds, c_ip, c_tl);
        end
        n_cmp++;
        if (u_in.rdy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_rdy: got %b required 1", u_in.rdy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_clean();
        int o0 = obs_out, d0 = obs_ds, i0 = obs_ip, t0 = obs_tl;
        logic [DW-1:0] d;
        d = {4{8'd34}};
        rdy_mode = 0;
        send_beat(1'b1, 1'b0, d, 2'd0);
        send_beat(1'b0, 1'b0, d, 2'd0);
        send_beat(1'b0, 1'b0, d, 2'd0);
        send_beat(1'b0, 1'b1, d, 2'd3);
        drain();
        n_cmp++;
        if (obs_out - o0 != 4 || obs_ds + obs_ip + obs_tl != d0 + i0 + t0) begin
            n_err++;
            $display("FAIL clean: got %0d beats %0d flags required 4 beats 0 flags",
                     obs_out - o0, obs_ds + obs_ip + obs_tl - d0 - i0 - t0);
        end
    endtask

    task automatic test_unstarted();
        int o0 = obs_out, d0 = obs_ds;
        send_beat(1'b0, 1'b0, DW'($urandom), 2'd0);
        send_beat(1'b0, 1'b0, DW'($urandom), 2'd0);
        send_beat(1'b1, 1'b0, DW'($urandom), 2'd0);
        send_beat(1'b0, 1'b0, DW'($urandom), 2'd0);
        send_beat(1'b0, 1'b1, DW'($urandom), 2'd1);
        drain();
        n_cmp++;
        if (obs_out - o0 != 3 || obs_ds - d0 != 2) begin
            n_err++;
            $display("FAIL unstarted: got %0d beats %0d pulses required 3 beats 2 pulses",
                     obs_out - o0, obs_ds - d0);
        end
    endtask

    task automatic test_pkt_in_pkt();
        int o0 = obs_out, d0 = obs_ds, i0 = obs_ip;
        send_beat(1'b1, 1'b0, DW'($urandom), 2'd0);
        send_beat(1'b0, 1'b0, DW'($urandom), 2'd0);
        send_beat(1'b0, 1'b0, DW'($urandom), 2'd0);
        send_beat(1'b1, 1'b0, DW'($urandom), 2'd2);
        send_beat(1'b0, 1'b0, DW'($urandom), 2'd0);
        send_beat(1'b0, 1'b0, DW'($urandom), 2'd0);
        send_beat(1'b0, 1'b1, DW'($urandom), 2'd1);
        drain();
        n_cmp++;
        if (obs_out - o0 != 4 || obs_ip - i0 != 1 || obs_ds - d0 != 3) begin
            n_err++;
            $display("FAIL pkt_in_pkt: got %0d beats ip %0d ds %0d required 4 1 3",
                     obs_out - o0, obs_ip - i0, obs_ds - d0);
        end
    endtask

    task automatic test_too_long();
        int o0 = obs_out, t0 = obs_tl, d0 = obs_ds;
        for (int i = 1; i <= 12; i++) send_beat(i == 1, i == 12, DW'($urandom), 2'd1);
        for (int i = 1; i <= 3; i++) send_beat(i == 1, i == 3, DW'($urandom), 2'd2);
        // Exactly MaxWords beats ending in eop is a normal packet.
        for (int i = 1; i <= MaxWords; i++) send_beat(i == 1, i == MaxWords, DW'($urandom), 2'd3);
        drain();
        n_cmp++;
        if (obs_out - o0 != 8 + 3 + MaxWords || obs_tl - t0 != 1 || obs_ds != d0) begin
            n_err++;
            $display("FAIL too_long: got %0d beats tl %0d ds %0d required %0d 1 0",
                     obs_out - o0, obs_tl - t0, obs_ds - d0, 11 + MaxWords);
        end
    endtask

    task automatic test_stall();
        int o0 = obs_out, s0 = obs_stall;
        rdy_mode = 1;
        tog_ph = 0;
        for (int i = 1; i <= 6; i++) send_beat(i == 1, i == 6, DW'($urandom), 2'd1);
        drain();
        n_cmp++;
        if (obs_out - o0 != 6 || obs_stall == s0) begin
            n_err++;
            $display("FAIL stall: got %0d beats %0d stall cycles required 6 beats and >0 stalls",
                     obs_out - o0, obs_stall - s0);
        end
    endtask

    task automatic test_err_cnt();
        logic [CntW-1:0] want;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        for (int i = 0; i < 5; i++) begin
            send_beat(1'b0, 1'b0, DW'($urandom), 2'd0);
            @(negedge clk);
`ifdef AVALON_ENFORCER_ERR_CNT_EN
            want = (i + 1 > 3) ? CntW'(3) : CntW'(i + 1);
`else
            want = '0;
`endif
            n_cmp++;
            if (c_ds !== want || c_ip !== '0 || c_tl !== '0) begin
                n_err++;
                $display("FAIL err_cnt[%0d]: got ds %0d ip %0d tl %0d required %0d 0 0", i,
                         c_ds, c_ip, c_tl, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        int o0 = obs_out;
        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            send_beat($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, DW'($urandom),
                      EW'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();
        n_cmp++;
        if (obs_out == o0) begin
            n_err++;
            $display("FAIL random_traffic: got 0 output beats required >0");
        end
    endtask

    task automatic test_reset_mid();
        int o0, d0;
        rdy_mode = 0;
        send_beat(1'b1, 1'b0, DW'($urandom), 2'd0);
        send_beat(1'b0, 1'b0, DW'($urandom), 2'd0);
        send_beat(1'b0, 1'b0, DW'($urandom), 2'd0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (u_out.valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_valid: got %b required 0", u_out.valid);
        end
        @(posedge clk);
        #1;
        o0 = obs_out;
        d0 = obs_ds;
        send_beat(1'b0, 1'b1, DW'($urandom), 2'd0);
        send_beat(1'b1, 1'b0, DW'($urandom), 2'd0);
        send_beat(1'b0, 1'b1, DW'($urandom), 2'd1);
        drain();
        n_cmp++;
        if (obs_out - o0 != 2 || obs_ds - d0 != 1) begin
            n_err++;
            $display("FAIL reset_mid: got %0d beats %0d ds required 2 beats 1 ds",
                     obs_out - o0, obs_ds - d0);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_unstarted();
        test_pkt_in_pkt();
        test_too_long();
        test_stall();
        test_err_cnt();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/avalon_packet_enforcer.md
Name: avalon_packet_enforcer

Overview:
- Parametrised successor to the Avalon-ST enforcer.
- Sits between an untrusted Avalon-ST source and trusted downstream logic.
- Repairs sop/eop framing:
  - drops beats received outside a packet;
  - closes a packet early when a new sop arrives before its eop;
  - truncates packets longer than MAX_PKT_WORDS.
- Adds a registered output stage with full valid/rdy backpressure, and per-error pulse flags.

Parameters:
- DATA_WIDTH_IN_BYTES, 16, data bus width in bytes; sets the avalon_st_if data and empty widths.
- MAX_PKT_WORDS, 64, maximum beats per output packet; legal range >= 2.
- CNT_WIDTH, 16, width of the optional error counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- untrusted_msg  avalon_st_if.slave  DATA_WIDTH_IN_BYTES  input stream (valid, sop, eop, data, empty, rdy).
- trusted_msg  avalon_st_if.master  DATA_WIDTH_IN_BYTES  repaired output stream.
- packet_didnt_started  out  1  one-cycle pulse: a beat was dropped because no packet was open.
- packet_in_packet  out  1  one-cycle pulse: sop arrived while a packet was open.
- packet_too_long  out  1  one-cycle pulse: a packet was truncated at MAX_PKT_WORDS.
- didnt_started_cnt  out  CNT_WIDTH  error count (optional feature).
- in_packet_cnt  out  CNT_WIDTH  error count (optional feature).
- too_long_cnt  out  CNT_WIDTH  error count (optional feature).

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-high on rst.
  - Reset values: trusted valid, sop, eop, data and empty = 0; all flags and counters = 0; state = IDLE; beat count = 0.
- Handshake:
  - untrusted rdy = !out_valid || trusted rdy (combinational).
  - A beat is accepted when untrusted valid && untrusted rdy.
  - Output register loads on an accepted, non-dropped beat. It holds while trusted valid && !trusted rdy, and clears valid when consumed with nothing new loaded.
  - Latency is 1 cycle, and throughput is one beat per cycle.
- Flags:
  - Registered pulses asserted in the cycle after the offending beat is accepted.
  - Independent of downstream stall.
- Data:
  - Passes through unmodified.
  - empty passes through only on beats emitted with eop=1 that carried input eop; it is forced to 0 on all other beats.
- Beat count:
  - Width $clog2(MAX_PKT_WORDS+1).
  - Counts beats emitted in the current packet.
- State machine (IDLE, IN_PKT, DROP). Within a state, sop is evaluated before eop and length.
  - IDLE:
    - sop&eop: emit, stay IDLE.
    - sop: emit, count=1, go IN_PKT.
    - no sop: drop, pulse packet_didnt_started.
  - IN_PKT:
    - sop: emit with sop=0, eop=1, empty=0; pulse packet_in_packet; go IDLE. The remaining beats of the new packet are dropped as unstarted.
    - eop: emit, go IDLE.
    - count+1 == MAX_PKT_WORDS: emit with eop=1, empty=0; pulse packet_too_long; go DROP.
    - otherwise: emit, count++.
  - DROP:
    - sop: handled exactly as in IDLE, with no flag.
    - eop: drop, go IDLE.
    - otherwise: drop.
- Boundary cases:
  - Input eop on exactly beat MAX_PKT_WORDS is a normal end: no flag, go IDLE.
  - A dropped beat is still accepted (rdy rules unchanged) and never reaches the output.
  - Reset mid-packet discards the output register and returns to IDLE. Downstream sees no eop for the aborted packet.

Optional Feature:
- Macro: AVALON_ENFORCER_ERR_CNT_EN.
- Defined:
  - Each flag pulse increments its CNT_WIDTH counter.
  - Counters saturate at all-ones and are cleared only by rst.
- Undefined:
  - The counter ports are present but tied to 0.
  - No counter registers are built.

Test Plan:
- Clean packet of 4 beats with data 8'd34 replicated, sop on beat 1, eop on beat 4 with empty=3, trusted rdy=1 -> identical 4 beats out, each 1 cycle later; empty=3 on the last beat; no flags.
- 2 beats with no sop while IDLE, then a clean 3-beat packet -> first 2 beats absent at output; packet_didnt_started pulses twice; 3-beat packet intact.
- sop, 2 beats, sop again, then 2 beats and eop -> 4 beats out, the 4th with eop=1, sop=0, empty=0; packet_in_packet pulses once; packet_didnt_started pulses 3 times.
- MAX_PKT_WORDS=8, 12-beat packet -> 8 beats out, beat 8 eop=1; packet_too_long pulses once; beats 9-12 dropped; the next sop packet passes intact.
- Clean 6-beat packet with trusted rdy toggling 1,0,0,1,... -> no beat lost or duplicated; untrusted rdy=0 exactly while output is full and stalled.
- With AVALON_ENFORCER_ERR_CNT_EN and CNT_WIDTH=2, 5 unstarted beats -> didnt_started_cnt = 1,2,3,3,3.
